// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width,
// iteration counter width and the controller state encoding.
package mult_pkg;

   localparam int WIDTH   = 8;
   localparam int COUNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done request bus of the shift-and-add multiplier; the requester
// side is the master, the multiplier is the slave.
interface shift_add_multiplier_if;

   logic                          start;
   logic [mult_pkg::WIDTH-1:0]    a;
   logic [mult_pkg::WIDTH-1:0]    b;
   logic                          busy;
   logic                          done;
   logic [2*mult_pkg::WIDTH-1:0]  product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );

endinterface

// File: rtl/ripple_carry_adder.sv
// 8-bit combinational ripple-carry adder with carry in and carry out.
module ripple_carry_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cy_in,
   output logic [7:0] sum,
   output logic       cy_Out
);

   logic carry;

   always_comb begin
      carry = cy_in;
      sum   = '0;
      for (int i = 0; i < 8; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cy_Out = carry;
   end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around the shared
// ripple_carry_adder. Optional early termination: MULT_EARLY_TERM_EN.
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = mult_pkg::WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   shift_add_multiplier_if.slave  bus
);

   if (WIDTH != 8) begin : g_width_check
      $error("shift_add_multiplier: WIDTH must be 8 to match the 8-bit adder instance");
   end

   state_t             state_q, state_d;
   logic [7:0]         m_q, m_d;
   logic [7:0]         p_q, p_d;
   logic [7:0]         q_q, q_d;
   logic               c_q, c_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [15:0]        product_q, product_d;

   logic [7:0]         add_b;
   logic [7:0]         sum;
   logic               cy_out;
   logic [16:0]        shifted;
   logic               last_iter;
   logic [15:0]        final_product;

   assign add_b = q_q[0] ? m_q : 8'h00;

   // C is zero on every RUN edge (cleared on start, shifted out as zero), so
   // feeding it back keeps the adder carry-in at 0 while keeping C observable.
   ripple_carry_adder u_adder (
      .a      (p_q),
      .b      (add_b),
      .cy_in  (c_q),
      .sum    (sum),
      .cy_Out (cy_out)
   );

   assign shifted = {cy_out, sum, q_q} >> 1;

`ifdef MULT_EARLY_TERM_EN
   logic [2:0] remain_iters;
   logic [7:0] remain_mask;

   // Unconsumed multiplier bits sit in the low end of Q after the shift; once
   // they are all zero the rest of the iterations would only shift right.
   assign remain_iters  = 3'd7 - count_q[2:0];
   assign remain_mask   = 8'h7F >> count_q[2:0];
   assign last_iter     = (count_q == COUNT_W'(7)) || ((shifted[7:0] & remain_mask) == 8'h00);
   assign final_product = 16'(shifted >> remain_iters);
`else
   assign last_iter     = (count_q == COUNT_W'(7));
   assign final_product = shifted[15:0];
`endif

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      p_d       = p_q;
      q_d       = q_q;
      c_d       = c_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               m_d     = bus.a;
               q_d     = bus.b;
               p_d     = 8'h00;
               c_d     = 1'b0;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            {c_d, p_d, q_d} = shifted;
            count_d         = count_q + COUNT_W'(1);
            if (last_iter) begin
               product_d = final_product;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         p_q       <= '0;
         q_q       <= '0;
         c_q       <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         p_q       <= p_d;
         q_q       <= q_d;
         c_q       <= c_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = (state_q == DONE);
   assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier; expected products are
// queued when an operation is launched and compared when done pulses.
module tb_shift_add_multiplier;
   import mult_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_total = 0;
   int   n_pass  = 0;
   logic [15:0] sb[$];

   shift_add_multiplier_if mbus ();

   shift_add_multiplier #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mbus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int run_cycles(input logic [7:0] bv);
      int r = 1;
      for (int i = 0; i < 8; i++) if (bv[i]) r = i + 1;
`ifndef MULT_EARLY_TERM_EN
      r = 8;
`endif
      return r;
   endfunction

   // Called #1 after the start edge; returns edges until done and busy samples.
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      while (mbus.done !== 1'b1 && lat < 20) begin
         if (mbus.busy === 1'b1) busy_cycles++;
         @(posedge clk); #1;
         lat++;
      end
      if (mbus.busy === 1'b1) busy_cycles++;
   endtask

   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input string tag);
      int lat, busy_cycles, r;
      logic [15:0] exp;
      r = run_cycles(bv);
      @(negedge clk);
      mbus.start = 1'b1;
      mbus.a = av;
      mbus.b = bv;
      sb.push_back(16'(av) * 16'(bv));
      @(posedge clk); #1;
      mbus.start = 1'b0;
      mbus.a = ~av;
      mbus.b = ~bv;
      wait_done(lat, busy_cycles);
      check({tag, " done_seen"}, 32'(mbus.done), 32'd1);
      check({tag, " latency"}, lat, r);
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      check({tag, " product"}, 32'(mbus.product), 32'(exp));
      check({tag, " busy_cycles"}, busy_cycles, r + 1);
      @(posedge clk); #1;
      check({tag, " done_one_cycle"}, 32'(mbus.done), 32'd0);
      check({tag, " idle_after"}, 32'(mbus.busy), 32'd0);
      check({tag, " product_held"}, 32'(mbus.product), 32'(exp));
   endtask

   initial begin
      int lat, busy_cycles, pulses;
      logic [15:0] exp;

      mbus.start = 1'b0;
      mbus.a = '0;
      mbus.b = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(mbus.busy), 32'd0);
      check("reset done", 32'(mbus.done), 32'd0);
      check("reset product", 32'(mbus.product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(8'hAF, 8'h5A, "basic");

      // Abort an operation a few cycles into RUN
      @(negedge clk);
      mbus.start = 1'b1;
      mbus.a = 8'hAF;
      mbus.b = 8'h5A;
      @(posedge clk); #1;
      mbus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("midrst busy_before", 32'(mbus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(mbus.busy), 32'd0);
      check("midrst done", 32'(mbus.done), 32'd0);
      check("midrst product", 32'(mbus.product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (mbus.done === 1'b1) pulses++;
      end
      check("midrst no_done", pulses, 0);
      check("midrst idle", 32'(mbus.busy), 32'd0);

      run_op(8'hFF, 8'hFF, "carry_ff");
      run_op(8'h56, 8'h88, "carry_56_88");
      run_op(8'h00, 8'hFF, "zero_a");
      run_op(8'hFF, 8'h00, "zero_b");
      run_op(8'hC3, 8'h01, "b_one");

      // Hold start high with new operands through RUN and DONE
      @(negedge clk);
      mbus.start = 1'b1;
      mbus.a = 8'h12;
      mbus.b = 8'h34;
      sb.push_back(16'h0012 * 16'h0034);
      @(posedge clk); #1;
      mbus.a = 8'h01;
      mbus.b = 8'h01;
      wait_done(lat, busy_cycles);
      check("busy_start done_seen", 32'(mbus.done), 32'd1);
      check("busy_start latency", lat, run_cycles(8'h34));
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      check("busy_start product", 32'(mbus.product), 32'(exp));
      @(posedge clk); #1;
      check("busy_start done_ignored", 32'(mbus.busy), 32'd0);
      check("busy_start product_held", 32'(mbus.product), 32'(exp));
      mbus.start = 1'b0;
      run_op(8'h01, 8'h01, "after_busy");

      run_op(8'd3, 8'd5, "b2b_first");
      run_op(8'd200, 8'd2, "b2b_second");

      check("scoreboard empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
